seg_timer_multi: RTL and testbench
==================================

# seg_timer_multi

Parametrised multi-digit up/down timer with registered 7-segment outputs. It is the next generation of the team's 3-digit 7-segment counter. It generalises digit count, step rate, display mode (plain decimal or mm:ss) and end-of-range behaviour (wrap or saturate). It adds run/stop/clear/load control and a terminal-count pulse. It sits between the board clock and the display drivers on the lab board.

## Interface
Parameters:
- NUM_DIGITS, 3, displayed digit count (≥2); digit 0 is least significant.
- TICK_DIV, 1, clk cycles per count step while running (≥1).
- CLOCK_MODE, 1, 0 = plain decimal (each digit 0–9); 1 = mm:ss (digit 0 = 0–9, digit 1 = 0–5, digits ≥2 = minutes, decimal).
- WRAP, 1, 1 = wrap at range end; 0 = saturate and stop.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  one clock; reset is synchronous and active-high.
- start  in  1  pulse: enter RUN.
- stop  in  1  pulse: leave RUN.
- clear  in  1  pulse: count to zero, IDLE.
- dir  in  1  0 = count up, 1 = count down; sampled every step.
- load  in  1  pulse: preset count from load_val.
- load_val  in  4*NUM_DIGITS  BCD preset, digit i at [4i+3:4i].
- bcd  out  4*NUM_DIGITS  current count, BCD.
- seg  out  8*NUM_DIGITS  segments, digit i at [8i+7:8i]; bit7=a … bit1=g, bit0=dp; active-high.
- running  out  1  high in RUN.
- tc  out  1  one-cycle pulse on reaching range end.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- States:
  - IDLE (count held).
  - RUN (prescaler active).
  - DONE (saturated; only with WRAP=0).
- Control priority, evaluated per edge: rst > clear > load > stop > start > step.
- Transitions:
  - IDLE --start--> RUN; RUN --stop--> IDLE.
  - RUN --saturate--> DONE; DONE --clear or valid load--> IDLE.
  - start in RUN or DONE is ignored; stop in IDLE or DONE is ignored.
- Prescaler:
  - 0..TICK_DIV-1, advances only in RUN.
  - When it is TICK_DIV-1, a step occurs and it returns to 0.
  - Cleared by start, clear, load and rst.
- Step: per-digit BCD ripple, with no division or multiplication.
  - Up: a digit increments; at its max (9, or 5 for mm:ss digit 1) it rolls to 0 and carries.
  - Down mirrors this with borrow.
- Range:
  - MAX = all 9s, except mm:ss digit 1 = 5.
  - MIN = all 0s.
- Up step at MAX, or down step at MIN:
  - WRAP=1: count goes to the opposite end (MIN or MAX), tc pulses, state stays RUN.
  - WRAP=0: count holds, tc pulses, state goes to DONE, running goes low.
- Load validation:
  - Rejected if any digit > 9, or if CLOCK_MODE=1 and digit 1 > 5.
  - On rejection: count unchanged, state unchanged, load_err pulses.
  - A valid load keeps RUN or IDLE and moves DONE to IDLE.
- Decode:
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=E6.
  - Any other code = 00.
  - dp is always 0.

## Timing
- Reset values: bcd=0; every seg digit=8'hFC; running=0; tc=0; load_err=0; state IDLE; prescaler 0.
- All outputs are registered.
- bcd and seg update on the same edge as the step, load or clear; seg is decoded from the next-state BCD.
- running rises on the edge that accepts start.
- First step after start: TICK_DIV edges after the start edge. With TICK_DIV=1, a step occurs on every following edge.
- tc is asserted in the cycle after the edge that hit the range end, for exactly one cycle.
- load_err follows the same one-cycle rule as tc.
- clear, load or rst mid-count takes effect on that edge; no step occurs that cycle.
- start and stop asserted together: stop wins, so the block enters or stays in IDLE.

## Structure
- Package seg_timer_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK (8'h00) constants.
  - The state encoding (IDLE, RUN, DONE).
  - The per-digit max function (digit index, CLOCK_MODE) → 9 or 5.
- Sub-module seg7_decode: combinational 4-bit BCD → 8-bit segment pattern, instantiated NUM_DIGITS times with generate.
- The top level holds the FSM, the prescaler and the BCD ripple chain.

## Test plan
- rst held for 2 cycles → bcd=0, seg=FC_FC_FC, running=0; start, dir=0, TICK_DIV=1, 60 steps → bcd=0x100, seg=60_FC_FC.
- load 0x958 then start (CLOCK_MODE=1, WRAP=1) → 0x959, then 0x000 with a single tc pulse, running stays 1.
- WRAP=0, dir=1, load 0x002 then start → 0x001, then 0x000 with tc; 0x000 held; running=0; start ignored; clear → IDLE.
- TICK_DIV=4: start → first step on the 4th edge after the start edge, then one step every 4 edges; stop at bcd 0x003 holds the count.
- load 0x07A and load 0x060 (CLOCK_MODE=1) → both rejected: load_err pulses, bcd unchanged; with CLOCK_MODE=0, load 0x060 is accepted.
- clear together with load, start together with stop, and rst mid-run → clear wins (bcd=0), stop wins (IDLE), reset values restored on the next edge.

Source files
------------

// File: rtl/seg_timer_pkg.sv
// Shared definitions for the multi-digit 7-segment timer: segment patterns,
// FSM state encoding and the per-digit range helper.
package seg_timer_pkg;

  // Segment patterns, bit7=a ... bit1=g, bit0=dp (dp never lit), active-high.
  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hE6;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // IDLE holds the count, RUN steps it, DONE is the saturated end (WRAP=0 only).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest legal value of a digit: the tens-of-seconds digit tops out at 5
  // in mm:ss mode, every other digit at 9.
  function automatic logic [3:0] digit_max(input int unsigned idx, input bit clock_mode);
    return (clock_mode && idx == 1) ? 4'd5 : 4'd9;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder; codes above 9 blank the digit.
module seg7_decode
  import seg_timer_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  // Table lookup with a blank default for illegal codes.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_timer_multi.sv
// Multi-digit up/down BCD timer with registered 7-segment outputs.
// Control pulses are resolved per edge in the order
// rst > clear > load > stop > start > step. An asserted stop also blocks
// start and the step on that edge even when it has nothing to stop. A start
// arriving while already running or done is ignored and does not block the
// step. Any load (accepted or rejected) clears the prescaler and blocks
// the step. The segment register is decoded from the next-state count, so
// bcd and seg always change on the same edge.
module seg_timer_multi
  import seg_timer_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int TICK_DIV   = 1,
  parameter int CLOCK_MODE = 1,
  parameter int WRAP       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    dir,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [8*NUM_DIGITS-1:0] seg,
  output logic                    running,
  output logic                    tc,
  output logic                    load_err
);

  localparam int            BW         = 4 * NUM_DIGITS;
  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam bit            CM         = (CLOCK_MODE != 0);
  localparam bit            WRAP_EN    = (WRAP != 0);

  state_t                  state_q, state_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [BW-1:0]           count_q, count_d;
  logic [BW-1:0]           ripple;
  logic                    ripple_end;
  logic                    load_ok;
  logic                    tc_d;
  logic                    load_err_d;
  logic [8*NUM_DIGITS-1:0] seg_d;

  assign bcd = count_q;

  // One step of the BCD ripple in the current direction; a carry/borrow out
  // of the top digit means the count was at the range end, and the rippled
  // value is then already the opposite end.
  always_comb begin : ripple_chain
    logic       carry;
    logic [3:0] d;
    carry  = 1'b1;
    d      = 4'd0;
    ripple = count_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = count_q[4*i +: 4];
      if (carry) begin
        if (!dir) begin
          if (d == digit_max(unsigned'(i), CM)) begin
            ripple[4*i +: 4] = 4'd0;
          end else begin
            ripple[4*i +: 4] = d + 4'd1;
            carry            = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            ripple[4*i +: 4] = digit_max(unsigned'(i), CM);
          end else begin
            ripple[4*i +: 4] = d - 4'd1;
            carry            = 1'b0;
          end
        end
      end
    end
    ripple_end = carry;
  end

  // A preset is legal only if every digit is within its own range.
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_val[4*i +: 4] > digit_max(unsigned'(i), CM)) begin
        load_ok = 1'b0;
      end
    end
  end

  // Next state, prescaler, count and pulse outputs in control-priority order.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    count_d    = count_q;
    tc_d       = 1'b0;
    load_err_d = 1'b0;
    if (clear) begin
      count_d = '0;
      state_d = IDLE;
      presc_d = '0;
    end else if (load) begin
      presc_d = '0;
      if (load_ok) begin
        count_d = load_val;
        if (state_q == DONE) begin
          state_d = IDLE;
        end
      end else begin
        load_err_d = 1'b1;
      end
    end else if (stop) begin
      if (state_q == RUN) begin
        state_d = IDLE;
      end
    end else if (start && state_q == IDLE) begin
      state_d = RUN;
      presc_d = '0;
    end else if (state_q == RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (ripple_end) begin
          tc_d = 1'b1;
          if (WRAP_EN) begin
            count_d = ripple;
          end else begin
            state_d = DONE;
          end
        end else begin
          count_d = ripple;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Decode the next-state count so the segments land with the count.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .bcd (count_d[4*g +: 4]),
      .seg (seg_d[8*g +: 8])
    );
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      count_q  <= '0;
      seg      <= {NUM_DIGITS{SEG_0}};
      running  <= 1'b0;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      count_q  <= count_d;
      seg      <= seg_d;
      running  <= (state_d == RUN);
      tc       <= tc_d;
      load_err <= load_err_d;
    end
  end

endmodule

// File: tb/tb_seg_timer_multi.sv
// Bench for seg_timer_multi: three instances with different parameter sets
// share one stimulus stream. An integer-valued model (count held as plain
// seconds or a decimal number) predicts every output each cycle; directed
// sequences add literal expectations.
module tb_seg_timer_multi;

  localparam int NI = 3;
  // Instance parameter sets: u0 mm:ss wrap, u1 decimal saturate /4, u2 mm:ss saturate.
  localparam int TD [NI] = '{1, 4, 1};
  localparam int CM [NI] = '{1, 0, 1};
  localparam int WR [NI] = '{1, 0, 0};
  localparam logic [7:0] SEG_TAB [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                          8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hE6};
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst, start, stop, clear, dir, load;
  logic [11:0] load_val;
  logic [11:0] bcd_o     [NI];
  logic [23:0] seg_o     [NI];
  logic        running_o [NI];
  logic        tc_o      [NI];
  logic        lerr_o    [NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seg_timer_multi #(.NUM_DIGITS(3), .TICK_DIV(1), .CLOCK_MODE(1), .WRAP(1)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .dir(dir),
    .load(load), .load_val(load_val), .bcd(bcd_o[0]), .seg(seg_o[0]),
    .running(running_o[0]), .tc(tc_o[0]), .load_err(lerr_o[0]));

  seg_timer_multi #(.NUM_DIGITS(3), .TICK_DIV(4), .CLOCK_MODE(0), .WRAP(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .dir(dir),
    .load(load), .load_val(load_val), .bcd(bcd_o[1]), .seg(seg_o[1]),
    .running(running_o[1]), .tc(tc_o[1]), .load_err(lerr_o[1]));

  seg_timer_multi #(.NUM_DIGITS(3), .TICK_DIV(1), .CLOCK_MODE(1), .WRAP(0)) u2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .dir(dir),
    .load(load), .load_val(load_val), .bcd(bcd_o[2]), .seg(seg_o[2]),
    .running(running_o[2]), .tc(tc_o[2]), .load_err(lerr_o[2]));

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Count is an integer: seconds in mm:ss mode, a plain number otherwise.
  function automatic int max_val(input int k);
    return (CM[k] != 0) ? (9 * 60 + 59) : 999;
  endfunction

  function automatic logic [11:0] to_bcd(input int v, input int k);
    int lo, hi;
    if (CM[k] != 0) begin
      lo = v % 60;
      hi = v / 60;
      return {4'(hi % 10), 4'(lo / 10), 4'(lo % 10)};
    end
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit load_legal(input logic [11:0] b, input int k);
    if (b[3:0] > 4'd9 || b[7:4] > 4'd9 || b[11:8] > 4'd9) return 1'b0;
    if (CM[k] != 0 && b[7:4] > 4'd5) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [11:0] b, input int k);
    int d0, d1, d2;
    d0 = int'(b[3:0]);
    d1 = int'(b[7:4]);
    d2 = int'(b[11:8]);
    return (CM[k] != 0) ? (d0 + 10 * d1 + 60 * d2) : (d0 + 10 * d1 + 100 * d2);
  endfunction

  function automatic logic [23:0] seg_of(input logic [11:0] b);
    logic [23:0] s;
    for (int i = 0; i < 3; i++) s[8*i +: 8] = SEG_TAB[b[4*i +: 4]];
    return s;
  endfunction

  int m_val   [NI];
  int m_state [NI];
  int m_presc [NI];
  bit m_tc    [NI];
  bit m_lerr  [NI];
  bit model_on = 1'b0;

  // Advance the model on every rising edge from the same inputs the DUTs see.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      m_tc[k]   = 1'b0;
      m_lerr[k] = 1'b0;
      if (rst || clear) begin
        m_val[k] = 0; m_state[k] = S_IDLE; m_presc[k] = 0;
      end else if (load) begin
        m_presc[k] = 0;
        if (load_legal(load_val, k)) begin
          m_val[k] = from_bcd(load_val, k);
          if (m_state[k] == S_DONE) m_state[k] = S_IDLE;
        end else begin
          m_lerr[k] = 1'b1;
        end
      end else if (stop) begin
        if (m_state[k] == S_RUN) m_state[k] = S_IDLE;
      end else if (start && m_state[k] == S_IDLE) begin
        m_state[k] = S_RUN; m_presc[k] = 0;
      end else if (m_state[k] == S_RUN) begin
        if (m_presc[k] == TD[k] - 1) begin
          m_presc[k] = 0;
          if ((!dir && m_val[k] == max_val(k)) || (dir && m_val[k] == 0)) begin
            m_tc[k] = 1'b1;
            if (WR[k] != 0) m_val[k] = dir ? max_val(k) : 0;
            else            m_state[k] = S_DONE;
          end else begin
            m_val[k] = dir ? m_val[k] - 1 : m_val[k] + 1;
          end
        end else begin
          m_presc[k]++;
        end
      end
    end
    if (rst) model_on = 1'b1;
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    if (model_on) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("u%0d.bcd", k), 32'(bcd_o[k]), 32'(to_bcd(m_val[k], k)));
        chk($sformatf("u%0d.seg", k), 32'(seg_o[k]), 32'(seg_of(to_bcd(m_val[k], k))));
        chk($sformatf("u%0d.running", k), 32'(running_o[k]), 32'(m_state[k] == S_RUN));
        chk($sformatf("u%0d.tc", k), 32'(tc_o[k]), 32'(m_tc[k]));
        chk($sformatf("u%0d.load_err", k), 32'(lerr_o[k]), 32'(m_lerr[k]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic do_load(input logic [11:0] v);
    load_val = v; load = 1'b1; cyc(); load = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    dir = 1'b0; load = 1'b0; load_val = '0;
    cyc(); cyc();
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst.u%0d.bcd", k), 32'(bcd_o[k]), 32'h000);
      chk($sformatf("rst.u%0d.seg", k), 32'(seg_o[k]), 32'hFCFCFC);
      chk($sformatf("rst.u%0d.running", k), 32'(running_o[k]), 32'h0);
    end

    // 60 up-steps in mm:ss: 00:00 -> 1:00.
    dir = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (60) cyc();
    chk("up60.u0.bcd", 32'(bcd_o[0]), 32'h100);
    chk("up60.u0.seg", 32'(seg_o[0]), 32'h60FCFC);
    stop = 1'b1; cyc(); stop = 1'b0;

    // Wrap at 9:59 in mm:ss.
    pulse_clear();
    do_load(12'h958);
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    chk("wrap.u0.959", 32'(bcd_o[0]), 32'h959);
    cyc();
    chk("wrap.u0.bcd0", 32'(bcd_o[0]), 32'h000);
    chk("wrap.u0.seg0", 32'(seg_o[0]), 32'hFCFCFC);
    chk("wrap.u0.tc", 32'(tc_o[0]), 32'h1);
    chk("wrap.u0.running", 32'(running_o[0]), 32'h1);
    cyc();
    chk("wrap.u0.tc_off", 32'(tc_o[0]), 32'h0);
    chk("wrap.u0.001", 32'(bcd_o[0]), 32'h001);
    stop = 1'b1; cyc(); stop = 1'b0;

    // Saturate counting down.
    pulse_clear();
    dir = 1'b1;
    do_load(12'h002);
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    chk("sat.u2.001", 32'(bcd_o[2]), 32'h001);
    cyc();
    chk("sat.u2.000", 32'(bcd_o[2]), 32'h000);
    chk("sat.u2.tc_early", 32'(tc_o[2]), 32'h0);
    cyc();
    chk("sat.u2.hold", 32'(bcd_o[2]), 32'h000);
    chk("sat.u2.tc", 32'(tc_o[2]), 32'h1);
    chk("sat.u2.running", 32'(running_o[2]), 32'h0);
    cyc();
    chk("sat.u2.tc_off", 32'(tc_o[2]), 32'h0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("sat.u2.start_ign", 32'(running_o[2]), 32'h0);
    cyc();
    chk("sat.u2.still_done", 32'(bcd_o[2]), 32'h000);
    pulse_clear();
    chk("sat.u2.cleared", 32'(running_o[2]), 32'h0);
    dir = 1'b0;

    // Prescaler /4 on u1.
    pulse_clear();
    start = 1'b1; cyc(); start = 1'b0;
    repeat (3) cyc();
    chk("div4.u1.pre", 32'(bcd_o[1]), 32'h000);
    cyc();
    chk("div4.u1.s1", 32'(bcd_o[1]), 32'h001);
    repeat (3) cyc();
    chk("div4.u1.s1hold", 32'(bcd_o[1]), 32'h001);
    cyc();
    chk("div4.u1.s2", 32'(bcd_o[1]), 32'h002);
    repeat (4) cyc();
    chk("div4.u1.s3", 32'(bcd_o[1]), 32'h003);
    stop = 1'b1; cyc(); stop = 1'b0;
    repeat (6) cyc();
    chk("div4.u1.stopped", 32'(bcd_o[1]), 32'h003);
    chk("div4.u1.running", 32'(running_o[1]), 32'h0);

    // Load validation.
    pulse_clear();
    do_load(12'h07A);
    chk("lerr.u0.07A", 32'(lerr_o[0]), 32'h1);
    chk("lerr.u1.07A", 32'(lerr_o[1]), 32'h1);
    chk("lerr.u0.bcd", 32'(bcd_o[0]), 32'h000);
    cyc();
    chk("lerr.u0.pulse_end", 32'(lerr_o[0]), 32'h0);
    do_load(12'h060);
    chk("lerr.u0.060", 32'(lerr_o[0]), 32'h1);
    chk("lerr.u2.060", 32'(lerr_o[2]), 32'h1);
    chk("lerr.u0.bcd060", 32'(bcd_o[0]), 32'h000);
    chk("lerr.u1.ok", 32'(lerr_o[1]), 32'h0);
    chk("lerr.u1.bcd060", 32'(bcd_o[1]), 32'h060);

    // Priority corners.
    load_val = 12'h123; load = 1'b1; clear = 1'b1; cyc(); load = 1'b0; clear = 1'b0;
    chk("prio.clear_load.u1", 32'(bcd_o[1]), 32'h000);
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("prio.start_stop.u0", 32'(running_o[0]), 32'h0);
    start = 1'b1; cyc(); start = 1'b0;
    repeat (5) cyc();
    chk("prio.run.u0", 32'(running_o[0]), 32'h1);
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("midrst.u%0d.bcd", k), 32'(bcd_o[k]), 32'h000);
      chk($sformatf("midrst.u%0d.seg", k), 32'(seg_o[k]), 32'hFCFCFC);
      chk($sformatf("midrst.u%0d.running", k), 32'(running_o[k]), 32'h0);
    end

    // Randomised control traffic checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      int mode;
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      clear = ($urandom_range(0, 79) == 0);
      load  = ($urandom_range(0, 29) == 0);
      rst   = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      mode = $urandom_range(0, 3);
      case (mode)
        0: load_val = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        1: load_val = {4'd9, 4'd5, 4'($urandom_range(5, 9))};
        2: load_val = {4'd0, 4'd0, 4'($urandom_range(0, 4))};
        default: load_val = 12'($urandom_range(0, 4095));
      endcase
      cyc();
    end
    start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0; rst = 1'b0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
